multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Moore FSM that sequences the shared multicycle MIPS datapath: single memory, register file, sign extender and ALU.
- Reuses the ALU and memory across cycles, one instruction at a time.
- Takes the opcode from the instruction register and a memory-ready handshake.
- Drives every datapath enable and mux select, including the 2-bit ALUOp consumed by ALU control.

Parameters:
- OPC_RTYPE, 6'b000000, R-type opcode
- OPC_LW, 6'b100011, load word opcode
- OPC_SW, 6'b101011, store word opcode
- OPC_BEQ, 6'b000100, branch-equal opcode
- OPC_ADDI, 6'b001000, add-immediate opcode
- OPC_J, 6'b000010, jump opcode

Ports:
- Clk, input, 1, the single clock
- Reset, input, 1, asynchronous, active-high
- opcode, input, 6, IR[31:26], sampled in DECODE
- memReady, input, 1, memory has completed the current access
- PCWrite, output, 1, unconditional PC load
- PCWriteCond, output, 1, PC load if ALU zero
- IorD, output, 1, memory address select: 0 = PC, 1 = ALUOut
- MemRead, output, 1, memory read request
- MemWrite, output, 1, memory write request
- IRWrite, output, 1, instruction register load
- MemToReg, output, 1, write-back select: 1 = MDR
- RegDST, output, 1, destination select: 1 = rd, 0 = rt
- RegWrite, output, 1, register file write enable
- ALUSrcA, output, 1, 0 = PC, 1 = register A
- ALUSrcB, output, 2, 00 = B, 01 = 4, 10 = sign-extend, 11 = sign-extend<<2
- AluOp, output, 2, 00 = add, 01 = sub, 10 = funct
- PCSource, output, 2, 00 = ALU, 01 = ALUOut, 10 = jump target
- illegalOp, output, 1, one-cycle pulse on an unknown opcode
- state, output, 4, current state (debug)

Behaviour:
- Clock and reset: one clock, Clk. Reset is asynchronous and active-high.
- While Reset=1:
  - state = FETCH (0).
  - All control outputs are forced to 0, including MemRead and illegalOp.
- Reset released:
  - FETCH outputs appear combinationally in the same cycle.
  - Reset asserted mid-instruction aborts it immediately; no partial write occurs once Reset=1.
- Outputs are a pure decode of state, except the memReady gating listed below. Unlisted outputs are 0.
- FETCH (0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, AluOp=00, PCSource=00.
  - IRWrite and PCWrite are asserted only when memReady=1.
  - Stay in FETCH while memReady=0; go to DECODE on memReady=1.
- DECODE (1): ALUSrcA=0, ALUSrcB=11, AluOp=00 (branch target into ALUOut).
  - lw/sw -> MEMADR (2)
  - R-type -> EXEC (6)
  - beq -> BRANCH (8)
  - addi -> ADDI_EX (9)
  - j -> JUMP (11)
  - any other opcode -> illegalOp=1 for this cycle, then FETCH
- MEMADR (2): ALUSrcA=1, ALUSrcB=10, AluOp=00. lw -> MEMRD (3); sw -> MEMWR (5). The opcode is held stable by the IR.
- MEMRD (3): MemRead=1, IorD=1. Wait for memReady, then go to MEMWB (4).
- MEMWB (4): RegWrite=1, MemToReg=1, RegDST=0. Next: FETCH.
- MEMWR (5): MemWrite=1, IorD=1. Wait for memReady, then go to FETCH. MemWrite is held high until memReady is seen.
- EXEC (6): ALUSrcA=1, ALUSrcB=00, AluOp=10. Next: RTYPEWB (7).
- RTYPEWB (7): RegWrite=1, RegDST=1, MemToReg=0. Next: FETCH.
- BRANCH (8): ALUSrcA=1, ALUSrcB=00, AluOp=01, PCWriteCond=1, PCSource=01. Next: FETCH.
- ADDI_EX (9): ALUSrcA=1, ALUSrcB=10, AluOp=00. Next: ADDI_WB (10).
- ADDI_WB (10): RegWrite=1, RegDST=0, MemToReg=0. Next: FETCH.
- JUMP (11): PCWrite=1, PCSource=10. Next: FETCH.
- Unused encodings 12-15 go to FETCH on the next edge, with all outputs 0.
- Latency in cycles with memReady always high: R-type 4, lw 5, sw 4, beq 3, addi 4, j 3, illegal 2.
- Every wait cycle in FETCH, MEMRD or MEMWR adds one cycle.
- memReady is ignored in all other states.

Optional Feature:
- Macro: MULTICYCLE_PERF_EN.
- Defined:
  - Adds two output ports: cycleCount (32 bits) and instrCount (32 bits).
  - Both reset to 0 asynchronously.
  - cycleCount increments on every Clk edge while not in reset.
  - instrCount increments on every transition into FETCH from a non-FETCH state. This includes the illegal-opcode return; it excludes FETCH wait cycles.
  - Both counters wrap from 0xFFFFFFFF to 0.
- Not defined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset high 3 cycles, then low, memReady=1: state=0, MemRead=1, IRWrite=1, PCWrite=1 in the first cycle after release; all outputs were 0 during reset.
- opcode=6'b100011, memReady=1: states 0,1,2,3,4,0. MEMWB has RegWrite=1, MemToReg=1, RegDST=0; lw takes 5 cycles in total.
- opcode=6'b101011, memReady low for 2 cycles in MEMWR: MemWrite=1 for 3 cycles, then FETCH; no RegWrite at any point.
- opcode=6'b000000, then 6'b000100, then 6'b000010: AluOp=10 in EXEC; AluOp=01 with PCWriteCond=1 in BRANCH; PCSource=10 with PCWrite=1 in JUMP.
- opcode=6'b111111: illegalOp high for exactly 1 cycle in DECODE, next state=FETCH; with MULTICYCLE_PERF_EN, instrCount increments by 1.
- Reset pulsed in MEMRD (state=3): state=0 immediately, MemRead=0 during reset, no RegWrite follows.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM; outputs are a Moore decode of state (FETCH/MEMRD/MEMWR wait on memReady).
// Latency: 3-5 cycles per instruction with memReady high, plus one per wait cycle; illegal opcode takes 2.
// Optional MULTICYCLE_PERF_EN adds cycleCount/instrCount performance counters.
module multicycle_control #(
    parameter logic [5:0] OPC_RTYPE = 6'b000000,
    parameter logic [5:0] OPC_LW    = 6'b100011,
    parameter logic [5:0] OPC_SW    = 6'b101011,
    parameter logic [5:0] OPC_BEQ   = 6'b000100,
    parameter logic [5:0] OPC_ADDI  = 6'b001000,
    parameter logic [5:0] OPC_J     = 6'b000010
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [5:0]  opcode,
    input  logic        memReady,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        MemToReg,
    output logic        RegDST,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  AluOp,
    output logic [1:0]  PCSource,
    output logic        illegalOp,
`ifdef MULTICYCLE_PERF_EN
    output logic [31:0] cycleCount,
    output logic [31:0] instrCount,
`endif
    output logic [3:0]  state
);

    localparam logic [3:0] FETCH   = 4'd0;
    localparam logic [3:0] DECODE  = 4'd1;
    localparam logic [3:0] MEMADR  = 4'd2;
    localparam logic [3:0] MEMRD   = 4'd3;
    localparam logic [3:0] MEMWB   = 4'd4;
    localparam logic [3:0] MEMWR   = 4'd5;
    localparam logic [3:0] EXEC    = 4'd6;
    localparam logic [3:0] RTYPEWB = 4'd7;
    localparam logic [3:0] BRANCH  = 4'd8;
    localparam logic [3:0] ADDI_EX = 4'd9;
    localparam logic [3:0] ADDI_WB = 4'd10;
    localparam logic [3:0] JUMP    = 4'd11;

    logic [3:0] next_state;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= FETCH;
        else       state <= next_state;
    end

    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH:   next_state = memReady ? DECODE : FETCH;
            DECODE: begin
                if (opcode == OPC_LW || opcode == OPC_SW) next_state = MEMADR;
                else if (opcode == OPC_RTYPE)             next_state = EXEC;
                else if (opcode == OPC_BEQ)               next_state = BRANCH;
                else if (opcode == OPC_ADDI)              next_state = ADDI_EX;
                else if (opcode == OPC_J)                 next_state = JUMP;
                else                                      next_state = FETCH;
            end
            MEMADR:  next_state = (opcode == OPC_SW) ? MEMWR : MEMRD;
            MEMRD:   next_state = memReady ? MEMWB : MEMRD;
            MEMWR:   next_state = memReady ? FETCH : MEMWR;
            EXEC:    next_state = RTYPEWB;
            ADDI_EX: next_state = ADDI_WB;
            default: next_state = FETCH;
        endcase
    end

    // Outputs are gated by Reset so nothing is written while reset is held.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemToReg    = 1'b0;
        RegDST      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        AluOp       = 2'b00;
        PCSource    = 2'b00;
        illegalOp   = 1'b0;
        if (!Reset) begin
            case (state)
                FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = memReady;
                    PCWrite = memReady;
                end
                DECODE: begin
                    ALUSrcB = 2'b11;
                    illegalOp = !(opcode == OPC_LW || opcode == OPC_SW || opcode == OPC_RTYPE ||
                                  opcode == OPC_BEQ || opcode == OPC_ADDI || opcode == OPC_J);
                end
                MEMADR, ADDI_EX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                MEMWB: begin
                    RegWrite = 1'b1;
                    MemToReg = 1'b1;
                end
                MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                EXEC: begin
                    ALUSrcA = 1'b1;
                    AluOp   = 2'b10;
                end
                RTYPEWB: begin
                    RegWrite = 1'b1;
                    RegDST   = 1'b1;
                end
                BRANCH: begin
                    ALUSrcA     = 1'b1;
                    AluOp       = 2'b01;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                end
                ADDI_WB: RegWrite = 1'b1;
                JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                end
                default: ;
            endcase
        end
    end

`ifdef MULTICYCLE_PERF_EN
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cycleCount <= 32'd0;
            instrCount <= 32'd0;
        end else begin
            cycleCount <= cycleCount + 32'd1;
            if (state != FETCH && next_state == FETCH)
                instrCount <= instrCount + 32'd1;
        end
    end
`endif

endmodule
